my_shift_arbiter: RTL
=====================

# my_shift_arbiter

Two-port arbiter and sequencer for the shared 32-bit logical right barrel shifter in the execute stage. It accepts shift requests from the ALU path (port 0) and the multi-cycle multiply/divide unit (port 1) using valid/ready handshakes, and grants one per cycle round-robin. It synthesizes arithmetic right shifts from the logical shifter by sign-fill masking and returns a registered result, tagged back to the requesting port.

## Interface
- DATA_WIDTH, 32, operand/result width; fixed by the shifter.
- SHAMT_WIDTH, 5, shift-amount width, log2(DATA_WIDTH).

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- req0_valid  in  1  port 0 request present
- req0_data  in  32  port 0 operand
- req0_shamt  in  5  port 0 shift amount
- req0_arith  in  1  port 0: 1 = arithmetic, 0 = logical
- req0_ready  out  1  port 0 request accepted this cycle
- resp0_valid  out  1  port 0 result valid
- resp0_data  out  32  port 0 result
- resp0_ready  in  1  port 0 consumer takes the result
- req1_*, resp1_*: identical set for port 1

## Operation
- Accept: req_i fires when req_i_valid & req_i_ready.
- Grant:
  - Only one valid: that port is granted.
  - Both valid: the port not in last_grant is granted.
  - last_grant updates only on a fire.
- Ready:
  - req_i_ready = grant_i & (~out_valid | drain), where drain = resp_ready of the port in out_tag.
  - Ready is combinational, never depends on req_i_ready, and is 0 while reset is high.
- Compute:
  - Granted operand goes through the sub-shifter combinationally.
  - If arith & data[31], OR in the mask ~(32'hFFFF_FFFF >> shamt).
  - Result is captured into out_data; out_tag = port; out_valid = 1.
- Output:
  - resp_i_valid = out_valid & (out_tag == i); resp_i_data = out_data for both ports.
  - The result holds stable until the tagged resp_ready is high.
- Drain without new fire: out_valid clears next cycle.
- Drain with fire in the same cycle: the register reloads and out_valid stays 1 (back-to-back throughput).
- Reset values: out_valid 0, out_data 0, out_tag 0, last_grant 1 (port 0 wins the first tie), all resp_valid 0.
- Reset mid-operation: a pending result is discarded and no response is emitted; requests presented during reset are not accepted.

## Timing
- Latency: fire in cycle N gives resp valid in cycle N+1.
- Throughput: 1 result/cycle while the tagged consumer holds resp_ready = 1.
- Stall: with out_valid = 1 and the tagged resp_ready = 0, both req_ready are 0, and out_data/out_tag are frozen.
- Fairness: with both ports continuously valid and responses drained, grants alternate 0,1,0,1…
- Shift amount 0: result equals the operand, with no sign fill.
- Shift amount 31, arithmetic, negative operand: result is 32'hFFFF_FFFF.
- No combinational path from resp_ready to resp_valid/resp_data. There is a combinational path from resp_ready to req_ready; this is the one permitted path.

## Structure
- Shared package/include:
  - DATA_WIDTH and SHAMT_WIDTH.
  - Port index constants PORT_ALU = 0, PORT_MDU = 1.
  - A full-ones constant used by the sign mask.
- One sub-module: the existing 32-bit right barrel shifter, instantiated once with data_input = granted operand, control_bits = granted shamt.
- The sign-fill mask uses a plain >> on the constant, not a second shifter instance.
- Arbitration, mask, and output register are local logic.

## Test plan
- Reset, then port 0 sends 32'h8000_0000, shamt 4, arith 0 → resp0 next cycle = 32'h0800_0000, resp1_valid stays 0.
- Same operand with arith 1 → 32'hF800_0000. Operand 32'h7000_0000, shamt 4, arith 1 → 32'h0700_0000.
- Both ports continuously valid with resp_ready = 1 → first grant port 0, then alternation. Each response's tag and data match the issuing port for 8 cycles.
- Port 1 result pending with resp1_ready = 0 for 3 cycles while port 0 is valid:
  - Both req_ready stay 0 and resp1_data stays stable.
  - When resp1_ready rises, port 0 fires in that same cycle and its result is valid the next cycle.
- shamt 0 and shamt 31, with operand 32'hDEAD_BEEF, logical and arithmetic → results 32'hDEAD_BEEF, 32'h0000_0001, 32'hFFFF_FFFF.
- Assert reset the cycle after a fire → no resp_valid, outputs 0, and the next tie after reset is granted to port 0.

Source files
------------

// File: rtl/my_shift_arbiter_pkg.sv
// Shared constants for the shift arbiter slice.
//   DATA_WIDTH / SHAMT_WIDTH : operand width and shift-amount width
//   PORT_ALU / PORT_MDU      : request port indices, also used as result tags
//   ALL_ONES                 : base constant for the arithmetic sign-fill mask
package my_shift_arbiter_pkg;
    localparam int DATA_WIDTH  = 32;
    localparam int SHAMT_WIDTH = 5;

    localparam logic PORT_ALU = 1'b0;
    localparam logic PORT_MDU = 1'b1;

    localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};
endpackage

// File: rtl/my_shift_arbiter_shifter.sv
// Logical right barrel shifter shared by the execute stage.
//   data_input   : operand
//   control_bits : shift amount
//   data_output  : data_input >> control_bits, zero filled
// Built as one conditional power-of-two stage per shift-amount bit.
module my_shift_arbiter_shifter
    import my_shift_arbiter_pkg::*;
(
    input  logic [DATA_WIDTH-1:0]  data_input,
    input  logic [SHAMT_WIDTH-1:0] control_bits,
    output logic [DATA_WIDTH-1:0]  data_output
);

    logic [DATA_WIDTH-1:0] stage;

    always_comb begin
        stage = data_input;
        for (int i = 0; i < SHAMT_WIDTH; i++) begin
            if (control_bits[i]) begin
                stage = stage >> (1 << i);
            end
        end
        data_output = stage;
    end

endmodule

// File: rtl/my_shift_arbiter.sv
// Two-port round-robin arbiter in front of the shared right barrel shifter.
// Port 0 is the ALU path, port 1 the multiply/divide unit. One request is
// granted per cycle; arithmetic shifts are made by OR-ing a sign-fill mask
// onto the logical shift. The result is registered and tagged to its port.
//   clock, reset           : rising-edge clock, synchronous active-high reset
//   reqN_valid/ready       : request handshake, port N
//   reqN_data/shamt/arith  : operand, shift amount, 1 = arithmetic shift
//   respN_valid/ready      : result handshake, port N
//   respN_data             : registered result (shared by both ports)
module my_shift_arbiter
    import my_shift_arbiter_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req0_valid,
    input  logic [DATA_WIDTH-1:0]  req0_data,
    input  logic [SHAMT_WIDTH-1:0] req0_shamt,
    input  logic                   req0_arith,
    output logic                   req0_ready,
    output logic                   resp0_valid,
    output logic [DATA_WIDTH-1:0]  resp0_data,
    input  logic                   resp0_ready,
    input  logic                   req1_valid,
    input  logic [DATA_WIDTH-1:0]  req1_data,
    input  logic [SHAMT_WIDTH-1:0] req1_shamt,
    input  logic                   req1_arith,
    output logic                   req1_ready,
    output logic                   resp1_valid,
    output logic [DATA_WIDTH-1:0]  resp1_data,
    input  logic                   resp1_ready
);

    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  out_data_q,  out_data_d;
    logic                   out_tag_q,   out_tag_d;
    logic                   last_grant_q, last_grant_d;

    logic                   grant_port;
    logic                   drain;
    logic                   can_load;
    logic                   fire;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic [SHAMT_WIDTH-1:0] sel_shamt;
    logic                   sel_arith;
    logic [DATA_WIDTH-1:0]  shifted;
    logic [DATA_WIDTH-1:0]  sign_mask;
    logic [DATA_WIDTH-1:0]  result;

    always_comb begin
        // Tie goes to the port that did not win last; a lone requester wins.
        if (req0_valid && req1_valid) begin
            grant_port = ~last_grant_q;
        end else if (req1_valid) begin
            grant_port = PORT_MDU;
        end else begin
            grant_port = PORT_ALU;
        end

        // Only the consumer the held result belongs to can free the register.
        drain    = (out_tag_q == PORT_MDU) ? resp1_ready : resp0_ready;
        can_load = ~out_valid_q | drain;

        req0_ready = ~reset & req0_valid & (grant_port == PORT_ALU) & can_load;
        req1_ready = ~reset & req1_valid & (grant_port == PORT_MDU) & can_load;
        fire       = (req0_valid & req0_ready) | (req1_valid & req1_ready);

        if (grant_port == PORT_MDU) begin
            sel_data  = req1_data;
            sel_shamt = req1_shamt;
            sel_arith = req1_arith;
        end else begin
            sel_data  = req0_data;
            sel_shamt = req0_shamt;
            sel_arith = req0_arith;
        end
    end

    my_shift_arbiter_shifter u_shifter (
        .data_input   (sel_data),
        .control_bits (sel_shamt),
        .data_output  (shifted)
    );

    always_comb begin
        // Bits vacated by the logical shift are the top shamt bits.
        sign_mask = ~(ALL_ONES >> sel_shamt);
        result    = shifted;
        if (sel_arith && sel_data[DATA_WIDTH-1]) begin
            result = shifted | sign_mask;
        end

        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_tag_d    = out_tag_q;
        last_grant_d = last_grant_q;
        if (fire) begin
            out_valid_d  = 1'b1;
            out_data_d   = result;
            out_tag_d    = grant_port;
            last_grant_d = grant_port;
        end else if (out_valid_q && drain) begin
            out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_tag_q    <= PORT_ALU;
            last_grant_q <= PORT_MDU;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_tag_q    <= out_tag_d;
            last_grant_q <= last_grant_d;
        end
    end

    // A result held when reset arrives is suppressed immediately so no
    // consumer can take it during the reset cycle.
    assign resp0_valid = ~reset & out_valid_q & (out_tag_q == PORT_ALU);
    assign resp1_valid = ~reset & out_valid_q & (out_tag_q == PORT_MDU);
    assign resp0_data  = out_data_q;
    assign resp1_data  = out_data_q;

endmodule
